wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single memory port.
// One transfer per grant; a DRAIN cycle absorbs the memory's trailing ack.
module wb_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // master 0
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic                  m0_we_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    // master 1
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic                  m1_we_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    // memory side
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic                  s_we_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;   // index of the master served most recently
    logic [7:0] cnt_q, cnt_d;

    logic req0, req1, g_req, sel1;

    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign g_req = gnt_q[1] ? req1 : req0;
    assign gnt_o = gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sel1     = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the master not served last wins
                    sel1    = (req0 && req1) ? ~last_q : req1;
                    gnt_d   = sel1 ? 2'b10 : 2'b01;
                    cnt_d   = 8'd0;
                    state_d = StBusy;
                end
            end

            StBusy: begin
                s_adr_o = gnt_q[1] ? m1_adr_i : m0_adr_i;
                s_dat_o = gnt_q[1] ? m1_dat_i : m0_dat_i;
                s_we_o  = gnt_q[1] ? m1_we_i  : m0_we_i;
                s_cyc_o = g_req;
                s_stb_o = g_req;
                if (gnt_q[1]) m1_dat_o = s_dat_i;
                else          m0_dat_o = s_dat_i;

                if (!g_req) begin
                    // Master abandoned the cycle: forward nothing
                    last_d  = gnt_q[1];
                    gnt_d   = 2'b00;
                    state_d = StDrain;
                end else if (s_ack_i) begin
                    m0_ack_o = gnt_q[0];
                    m1_ack_o = gnt_q[1];
                    last_d   = gnt_q[1];
                    gnt_d    = 2'b00;
                    state_d  = StDrain;
                end else if (cnt_q == TimeoutCnt) begin
                    m0_err_o = gnt_q[0];
                    m1_err_o = gnt_q[1];
                    last_d   = gnt_q[1];
                    gnt_d    = 2'b00;
                    state_d  = StDrain;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StDrain: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a registered-ack memory model.
module tb_wb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_we_i, m0_stb_i, m0_cyc_i;
    logic          m1_we_i, m1_stb_i, m1_cyc_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]    gnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_ack0 = 0;
    int n_ack1 = 0;
    int n_err0 = 0;
    int n_err1 = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_we_i  (m0_we_i),
        .m0_stb_i (m0_stb_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_we_i  (m1_we_i),
        .m1_stb_i (m1_stb_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    // Memory model: ack registered and held while cyc&stb keeps arriving
    logic [DW-1:0] mem [256];
    logic          mem_ack_q;
    logic          ack_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack_q <= 1'b0;
        end else begin
            mem_ack_q <= s_cyc_o & s_stb_o & ack_en;
            if (s_cyc_o && s_stb_o && s_we_o) mem[s_adr_o[7:0]] <= s_dat_o;
        end
    end

    assign s_ack_i = mem_ack_q;
    assign s_dat_i = (s_cyc_o && s_stb_o && !s_we_o) ? mem[s_adr_o[7:0]] : '0;

    always @(posedge clk) begin
        if (m0_ack_o) n_ack0 <= n_ack0 + 1;
        if (m1_ack_o) n_ack1 <= n_ack1 + 1;
        if (m0_err_o) n_err0 <= n_err0 + 1;
        if (m1_err_o) n_err1 <= n_err1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic cyc, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
        m0_cyc_i = cyc;
        m0_stb_i = cyc;
        m0_we_i  = we;
        m0_adr_i = adr;
        m0_dat_i = dat;
    endtask

    task automatic drive1(input logic cyc, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
        m1_cyc_i = cyc;
        m1_stb_i = cyc;
        m1_we_i  = we;
        m1_adr_i = adr;
        m1_dat_i = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_gnt;
        rst_n  = 1'b0;
        ack_en = 1'b1;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);

        // Reset state
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("rst_m0_err", 32'(m0_err_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write by m0 then read-back by m1
        @(negedge clk);
        drive0(1'b1, 1'b1, 14'h0010, 32'hDEADBEEF);
        #1 chk("wr_idle_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("wr_gnt", 32'(gnt_o), 32'h1);
        chk("wr_s_cyc", 32'(s_cyc_o), 32'h1);
        chk("wr_s_adr", 32'(s_adr_o), 32'h10);
        chk("wr_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("wr_s_we", 32'(s_we_o), 32'h1);
        chk("wr_ack_early", 32'(m0_ack_o), 32'h0);
        @(negedge clk); #1;
        chk("wr_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("wr_m1_ack", 32'(m1_ack_o), 32'h0);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        #1;
        chk("wr_drain_gnt", 32'(gnt_o), 32'h0);
        chk("wr_drain_ack", 32'(m0_ack_o), 32'h0);
        chk("wr_drain_cyc", 32'(s_cyc_o), 32'h0);
        @(negedge clk);

        @(negedge clk);
        drive1(1'b1, 1'b0, 14'h0010, '0);
        #1 chk("rd_idle_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("rd_gnt", 32'(gnt_o), 32'h2);
        chk("rd_s_we", 32'(s_we_o), 32'h0);
        chk("rd_s_adr", 32'(s_adr_o), 32'h10);
        @(negedge clk); #1;
        chk("rd_m1_ack", 32'(m1_ack_o), 32'h1);
        chk("rd_m1_dat", m1_dat_o, 32'hDEADBEEF);
        chk("rd_m0_dat", m0_dat_o, 32'h0);
        @(negedge clk);
        drive1(1'b0, 1'b0, '0, '0);
        #1 chk("rd_drain_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk);

        // Fresh reset, then sustained contention: strict alternation from m0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive0(1'b1, 1'b0, 14'h0010, '0);
        drive1(1'b1, 1'b0, 14'h0010, '0);
        #1 chk("cont_idle_gnt", 32'(gnt_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk); #1;
            chk($sformatf("cont_gnt_%0d", i), 32'(gnt_o), 32'(exp_gnt));
            @(negedge clk); #1;
            chk($sformatf("cont_m0_ack_%0d", i), 32'(m0_ack_o), 32'(exp_gnt[0]));
            chk($sformatf("cont_m1_ack_%0d", i), 32'(m1_ack_o), 32'(exp_gnt[1]));
            @(negedge clk);
            if (i == 3) begin
                drive0(1'b0, 1'b0, '0, '0);
                drive1(1'b0, 1'b0, '0, '0);
            end
            #1;
            chk($sformatf("trail_m0_ack_%0d", i), 32'(m0_ack_o), 32'h0);
            chk($sformatf("trail_m1_ack_%0d", i), 32'(m1_ack_o), 32'h0);
            chk($sformatf("trail_gnt_%0d", i), 32'(gnt_o), 32'h0);
            @(negedge clk); #1;
            chk($sformatf("cont_idle_%0d", i), 32'(gnt_o), 32'h0);
        end

        // Timeout: memory never acks
        ack_en = 1'b0;
        @(negedge clk);
        drive0(1'b1, 1'b1, 14'h0020, 32'h00001234);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); #1;
            chk($sformatf("to_err_low_%0d", i), 32'(m0_err_o), 32'h0);
            chk($sformatf("to_ack_low_%0d", i), 32'(m0_ack_o), 32'h0);
            if (i == 1) chk("to_gnt", 32'(gnt_o), 32'h1);
        end
        @(negedge clk); #1;
        chk("to_err_pulse", 32'(m0_err_o), 32'h1);
        chk("to_ack_none", 32'(m0_ack_o), 32'h0);
        chk("to_m1_err", 32'(m1_err_o), 32'h0);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        #1;
        chk("to_err_single", 32'(m0_err_o), 32'h0);
        chk("to_drain_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("to_idle_gnt", 32'(gnt_o), 32'h0);
        ack_en = 1'b1;

        // Abort: m1 wins the tie (m0 served last), then drops cyc
        @(negedge clk);
        drive0(1'b1, 1'b1, 14'h0030, 32'hCAFEF00D);
        drive1(1'b1, 1'b0, 14'h0010, '0);
        @(negedge clk); #1;
        chk("ab_gnt_m1", 32'(gnt_o), 32'h2);
        @(negedge clk);
        drive1(1'b0, 1'b0, '0, '0);
        #1;
        chk("ab_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("ab_m1_ack", 32'(m1_ack_o), 32'h0);
        chk("ab_m1_err", 32'(m1_err_o), 32'h0);
        @(negedge clk); #1;
        chk("ab_drain_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("ab_idle_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("ab_gnt_m0", 32'(gnt_o), 32'h1);
        chk("ab_s_dat", s_dat_o, 32'hCAFEF00D);
        @(negedge clk); #1;
        chk("ab_m0_ack", 32'(m0_ack_o), 32'h1);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Asynchronous reset in the middle of a BUSY cycle
        @(negedge clk);
        drive0(1'b1, 1'b0, 14'h0010, '0);
        drive1(1'b1, 1'b0, 14'h0010, '0);
        @(negedge clk); #1;
        chk("ar_gnt_before", 32'(gnt_o), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt_o), 32'h0);
        chk("ar_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("ar_s_adr", 32'(s_adr_o), 32'h0);
        chk("ar_m1_ack", 32'(m1_ack_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_rel_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk); #1;
        chk("ar_first_tie", 32'(gnt_o), 32'h1);
        @(negedge clk); #1;
        chk("ar_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("ar_m1_ack2", 32'(m1_ack_o), 32'h0);
        @(negedge clk);
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        // Totals: one ack per completed transfer, one err pulse overall
        chk("tot_ack0", 32'(n_ack0), 32'd5);
        chk("tot_ack1", 32'(n_ack1), 32'd3);
        chk("tot_err0", 32'(n_err0), 32'd1);
        chk("tot_err1", 32'(n_err1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
